// File: rtl/imem_loader_if.sv
// imem_loader_if: byte stream valid/ready handshake
// feeding the boot-time instruction memory loader.
interface imem_loader_if;
  logic [7:0] in_byte;
  logic       in_valid;
  logic       in_ready;

  modport master (
    output in_byte,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_byte,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: assembles a framed byte stream into instruction words,
// writes them to imem and holds the core in reset until the checksum verifies.
module imem_loader #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  imem_loader_if.slave          stream,
  output logic                  imem_we,
  output logic [31:0]           imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_reset,
  output logic                  done,
  output logic                  error,
  output logic [DEPTH_LOG2:0]   words_loaded
);

  localparam int CW = DEPTH_LOG2 + 1;
  localparam logic [16:0] MAX_N = 17'(1) << DEPTH_LOG2;
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic [2:0] {
    LEN0,
    LEN1,
    DATA,
    CSUM,
    RUN,
    ERROR
  } state_t;

  state_t        state;
  logic          ready;
  logic          fire;
  logic [7:0]    b;
  logic [7:0]    len_lo;
  logic [7:0]    csum;
  logic [CW-1:0] len;
  logic [CW-1:0] widx;
  logic [1:0]    bcnt;
  logic [23:0]   shreg;
  logic [16:0]   n;

  assign stream.in_ready = ready;
  assign b    = stream.in_byte;
  assign fire = stream.in_valid && ready;
  assign n    = {1'b0, b, len_lo};

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= LEN0;
      ready        <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      core_reset   <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
      csum         <= '0;
      bcnt         <= '0;
      len_lo       <= '0;
      len          <= '0;
      widx         <= '0;
      shreg        <= '0;
    end else begin
      imem_we <= 1'b0;
      if (imem_we)
        words_loaded <= words_loaded + ONE;
      case (state)
        LEN0: begin
          ready <= 1'b1;
          if (fire) begin
            len_lo <= b;
            csum   <= csum ^ b;
            state  <= LEN1;
          end
        end
        LEN1: begin
          if (fire) begin
            csum <= csum ^ b;
            len  <= n[CW-1:0];
            if (n > MAX_N) begin
              state <= ERROR;
              ready <= 1'b0;
              error <= 1'b1;
            end else if (n == 17'd0) begin
              state <= CSUM;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (fire) begin
            csum  <= csum ^ b;
            bcnt  <= bcnt + 2'd1;
            shreg <= {b, shreg[23:8]};
            // 4th byte completes the word; first byte sits in [7:0]
            if (bcnt == 2'd3) begin
              imem_we    <= 1'b1;
              imem_addr  <= 32'(widx) << 2;
              imem_wdata <= {b, shreg};
              widx       <= widx + ONE;
              if (widx == len - ONE)
                state <= CSUM;
            end
          end
        end
        CSUM: begin
          if (fire) begin
            ready <= 1'b0;
            if (b == csum) begin
              state      <= RUN;
              done       <= 1'b1;
              core_reset <= 1'b0;
            end else begin
              state <= ERROR;
              error <= 1'b1;
            end
          end
        end
        RUN, ERROR: ready <= 1'b0;
        default: begin
          state <= ERROR;
          ready <= 1'b0;
          error <= 1'b1;
        end
      endcase
    end
  end

endmodule
